controller: RTL

CONTROLLER -- requirements
Module: controller

---
 rtl/controller_pkg.sv | 55 +++++
 rtl/controller_if.sv | 26 ++
 rtl/controller_alu_control.sv | 24 ++
 rtl/controller.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/controller_pkg.sv
// Shared encodings for the multicycle MIPS-style controller: FSM states,
// instruction fields, ALU operation codes and datapath mux selects.
package controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_LWREAD  = 4'd3,
    S_LWWB    = 4'd4,
    S_SWWRITE = 4'd5,
    S_RTEX    = 4'd6,
    S_RTWB    = 4'd7,
    S_BRANCH  = 4'd8,
    S_IMMEX   = 4'd9,
    S_IMMWB   = 4'd10,
    S_JUMP    = 4'd11,
    S_JAL     = 4'd12,
    S_JR      = 4'd13
  } state_e;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BNE   = 6'b000101;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_SLTI  = 6'b001010;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_JAL   = 6'b000011;

  localparam logic [5:0] FUNC_ADD  = 6'b100000;
  localparam logic [5:0] FUNC_SUB  = 6'b100010;
  localparam logic [5:0] FUNC_AND  = 6'b100100;
  localparam logic [5:0] FUNC_OR   = 6'b100101;
  localparam logic [5:0] FUNC_SLT  = 6'b101010;
  localparam logic [5:0] FUNC_JR   = 6'b001000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_JUMP   = 2'b01;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b10;
  localparam logic [1:0] PCSRC_AREG   = 2'b11;

endpackage

// File: rtl/controller_if.sv
// Controller <-> datapath bundle: instruction fields and zero flag in,
// datapath control strobes and mux selects out.
interface controller_if;
  logic [5:0] opc;
  logic [5:0] func;
  logic       zero;
  logic       PCLoad, IorD, MemRead, MemWrite, IRWrite, RegDst;
  logic       JalSig1, MemToReg, JalSig2, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOperation;
  logic [1:0] PCSrc;

  modport master (
    input  opc, func, zero,
    output PCLoad, IorD, MemRead, MemWrite, IRWrite, RegDst,
           JalSig1, MemToReg, JalSig2, RegWrite, ALUSrcA,
           ALUSrcB, ALUOperation, PCSrc
  );

  modport slave (
    output opc, func, zero,
    input  PCLoad, IorD, MemRead, MemWrite, IRWrite, RegDst,
           JalSig1, MemToReg, JalSig2, RegWrite, ALUSrcA,
           ALUSrcB, ALUOperation, PCSrc
  );
endinterface

// File: rtl/controller_alu_control.sv
// R-type function field to ALU operation decode; func_ok flags a
// supported function so the FSM can skip the register write otherwise.
module alu_control
  import controller_pkg::*;
(
  input  logic [5:0] func,
  output logic [2:0] alu_op,
  output logic       func_ok
);

  always_comb begin
    alu_op  = ALU_ADD;
    func_ok = 1'b1;
    case (func)
      FUNC_ADD: alu_op = ALU_ADD;
      FUNC_SUB: alu_op = ALU_SUB;
      FUNC_AND: alu_op = ALU_AND;
      FUNC_OR:  alu_op = ALU_OR;
      FUNC_SLT: alu_op = ALU_SLT;
      default:  func_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/controller.sv
// Multicycle controller FSM: Moore-decoded datapath controls, except branch
// PCLoad which follows the ALU zero flag. rst forces every output low.
module controller
  import controller_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  controller_if.master bus
);

  state_e     state_q, state_d;
  logic [2:0] rt_alu_op;
  logic       rt_func_ok;

  logic       pc_load, iord, mem_read, mem_write, ir_write, reg_dst;
  logic       jal_sig1, mem_to_reg, jal_sig2, reg_write, alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_operation;
  logic [1:0] pc_src;

  alu_control u_alu_control (
    .func    (bus.func),
    .alu_op  (rt_alu_op),
    .func_ok (rt_func_ok)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_load       = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    jal_sig1      = 1'b0;
    mem_to_reg    = 1'b0;
    jal_sig2      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_operation = ALU_AND;
    pc_src        = PCSRC_ALU;

    case (state_q)
      S_FETCH: begin
        mem_read      = 1'b1;
        ir_write      = 1'b1;
        alu_src_b     = SRCB_FOUR;
        alu_operation = ALU_ADD;
        pc_load       = 1'b1;
        state_d       = S_DECODE;
      end
      S_DECODE: begin
        // Speculatively compute the branch target while the opcode is decoded.
        alu_src_b     = SRCB_IMMSH2;
        alu_operation = ALU_ADD;
        case (bus.opc)
          OPC_LW, OPC_SW:     state_d = S_MEMADR;
          OPC_RTYPE:          state_d = (bus.func == FUNC_JR) ? S_JR : S_RTEX;
          OPC_BEQ, OPC_BNE:   state_d = S_BRANCH;
          OPC_ADDI, OPC_SLTI: state_d = S_IMMEX;
          OPC_J:              state_d = S_JUMP;
          OPC_JAL:            state_d = S_JAL;
          default:            state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_IMM;
        alu_operation = ALU_ADD;
        state_d       = (bus.opc == OPC_LW) ? S_LWREAD : S_SWWRITE;
      end
      S_LWREAD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        state_d  = S_LWWB;
      end
      S_LWWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_SWWRITE: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_RTEX: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_B;
        alu_operation = rt_alu_op;
        state_d       = rt_func_ok ? S_RTWB : S_FETCH;
      end
      S_RTWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_B;
        alu_operation = ALU_SUB;
        pc_src        = PCSRC_ALUOUT;
        pc_load       = (bus.opc == OPC_BNE) ? ~bus.zero : bus.zero;
        state_d       = S_FETCH;
      end
      S_IMMEX: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_IMM;
        alu_operation = (bus.opc == OPC_SLTI) ? ALU_SLT : ALU_ADD;
        state_d       = S_IMMWB;
      end
      S_IMMWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_src  = PCSRC_JUMP;
        pc_load = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        // Link and jump in one cycle: $31 captures the already-incremented PC.
        jal_sig1  = 1'b1;
        jal_sig2  = 1'b1;
        reg_write = 1'b1;
        pc_src    = PCSRC_JUMP;
        pc_load   = 1'b1;
        state_d   = S_FETCH;
      end
      S_JR: begin
        pc_src  = PCSRC_AREG;
        pc_load = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    if (rst) begin
      pc_load       = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_dst       = 1'b0;
      jal_sig1      = 1'b0;
      mem_to_reg    = 1'b0;
      jal_sig2      = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_B;
      alu_operation = ALU_AND;
      pc_src        = PCSRC_ALU;
    end
  end

  assign bus.PCLoad       = pc_load;
  assign bus.IorD         = iord;
  assign bus.MemRead      = mem_read;
  assign bus.MemWrite     = mem_write;
  assign bus.IRWrite      = ir_write;
  assign bus.RegDst       = reg_dst;
  assign bus.JalSig1      = jal_sig1;
  assign bus.MemToReg     = mem_to_reg;
  assign bus.JalSig2      = jal_sig2;
  assign bus.RegWrite     = reg_write;
  assign bus.ALUSrcA      = alu_src_a;
  assign bus.ALUSrcB      = alu_src_b;
  assign bus.ALUOperation = alu_operation;
  assign bus.PCSrc        = pc_src;

endmodule
